pipelined_shifter: RTL



---
 rtl/pipelined_shifter.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/pipelined_shifter.sv
// Pipelined N-bit shifter/rotator (SLL, SRL, SRA, ROL) with valid/ready on both sides.
// Define SHIFTER_STICKY_EN to add the out_sticky port (OR of all bits shifted out).
module pipelined_shifter #(
    parameter int unsigned N           = 32,
    parameter int unsigned PIPE_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [N-1:0]         in_x,
    input  logic [$clog2(N)-1:0] in_d,
    input  logic [1:0]           in_op,
    output logic                 out_valid,
    input  logic                 out_ready,
`ifdef SHIFTER_STICKY_EN
    output logic                 out_sticky,
`endif
    output logic [N-1:0]         out_z
);
    localparam int unsigned D_WIDTH = $clog2(N);

    // Apply mux levels lo..hi; every level shifts by 2^i < N, so ROL wraps mod N for free.
    function automatic logic [N-1:0] shift_levels(input logic [N-1:0] x, input logic [1:0] op,
                                                  input logic [D_WIDTH-1:0] d, input logic sign,
                                                  input int unsigned lo, input int unsigned hi);
        logic [N-1:0] r;
        int unsigned  s;
        r = x;
        for (int unsigned i = 0; i < D_WIDTH; i++) begin
            s = 32'd1 << i;
            if (i >= lo && i <= hi && d[i]) begin
                case (op)
                    2'b00:   r = r << s;
                    2'b01:   r = r >> s;
                    2'b10:   r = (r >> s) | ({N{sign}} & ~({N{1'b1}} >> s));
                    default: r = (r << s) | (r >> (N - s));
                endcase
            end
        end
        return r;
    endfunction

`ifdef SHIFTER_STICKY_EN
    function automatic logic sticky_levels(input logic [N-1:0] x, input logic [1:0] op,
                                           input logic [D_WIDTH-1:0] d, input logic sign,
                                           input int unsigned lo, input int unsigned hi);
        logic [N-1:0] r;
        logic         st;
        int unsigned  s;
        r  = x;
        st = 1'b0;
        for (int unsigned i = 0; i < D_WIDTH; i++) begin
            s = 32'd1 << i;
            if (i >= lo && i <= hi && d[i]) begin
                case (op)
                    2'b00:        st = st | (|(r >> (N - s)));
                    2'b01, 2'b10: st = st | (|(r << (N - s)));
                    default:      st = st;
                endcase
                r = shift_levels(r, op, d, sign, i, i);
            end
        end
        return st;
    endfunction
`endif

    // Index 0 is the input port, index k+1 is the output of register stage k.
    logic [N-1:0]         st_x    [PIPE_STAGES+1];
    logic [1:0]           st_op   [PIPE_STAGES];
    logic [D_WIDTH-1:0]   st_d    [PIPE_STAGES];
    logic                 st_sign [PIPE_STAGES];
    logic [PIPE_STAGES:0] st_valid;
    logic [PIPE_STAGES:0] rdy;

    assign st_x[0]     = in_x;
    assign st_op[0]    = in_op;
    assign st_d[0]     = in_d;
    assign st_sign[0]  = in_x[N-1];
    assign st_valid[0] = in_valid;
    assign rdy[PIPE_STAGES] = out_ready;
    assign in_ready    = rdy[0];

`ifdef SHIFTER_STICKY_EN
    logic st_sticky [PIPE_STAGES+1];
    assign st_sticky[0] = 1'b0;
`endif

    for (genvar k = 0; k < PIPE_STAGES; k++) begin : g_stage
        localparam int unsigned Lo = (k * D_WIDTH + PIPE_STAGES - 1) / PIPE_STAGES;
        localparam int unsigned Hi = ((k + 1) * D_WIDTH + PIPE_STAGES - 1) / PIPE_STAGES - 1;

        logic         valid_q;
        logic [N-1:0] x_q;
        logic         ld;

        // A stage accepts when empty or when its occupant moves on this cycle.
        assign rdy[k] = !valid_q || rdy[k+1];
        assign ld     = rdy[k] && st_valid[k];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                valid_q <= 1'b0;
                x_q     <= '0;
            end else begin
                if (rdy[k]) valid_q <= st_valid[k];
                if (ld) x_q <= shift_levels(st_x[k], st_op[k], st_d[k], st_sign[k], Lo, Hi);
            end
        end

        assign st_x[k+1]     = x_q;
        assign st_valid[k+1] = valid_q;

        if (k < PIPE_STAGES - 1) begin : g_ctrl
            logic [1:0]         op_q;
            logic [D_WIDTH-1:0] d_q;
            logic               sign_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    op_q   <= '0;
                    d_q    <= '0;
                    sign_q <= 1'b0;
                end else if (ld) begin
                    op_q   <= st_op[k];
                    d_q    <= st_d[k];
                    sign_q <= st_sign[k];
                end
            end

            assign st_op[k+1]   = op_q;
            assign st_d[k+1]    = d_q;
            assign st_sign[k+1] = sign_q;
        end

`ifdef SHIFTER_STICKY_EN
        logic sticky_q;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sticky_q <= 1'b0;
            end else if (ld) begin
                sticky_q <= st_sticky[k] |
                            sticky_levels(st_x[k], st_op[k], st_d[k], st_sign[k], Lo, Hi);
            end
        end
        assign st_sticky[k+1] = sticky_q;
`endif
    end

    assign out_valid = st_valid[PIPE_STAGES];
    assign out_z     = st_x[PIPE_STAGES];
`ifdef SHIFTER_STICKY_EN
    assign out_sticky = st_sticky[PIPE_STAGES];
`endif

endmodule
